// File: rtl/if_ctrl.sv
// Instruction-fetch controller: PC sequencing, branch redirect, hazard hold
// and handover of the instruction memory to a program loader.
module if_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_LIMIT = 32'd4000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        BR_TAKEN,
  input  logic [31:0] BR_TARGET,
  input  logic        LD_REQ,
  input  logic        LD_DONE,
  output logic [31:0] FETCH_ADR,
  output logic        FETCH_VALID,
  output logic        SQUASH,
  output logic        LD_GNT,
  output logic [15:0] STALL_CNT
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, LOAD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [15:0] cnt, cnt_nxt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Sequential advance wraps on passing the limit or on 32-bit carry-out.
  function automatic logic [31:0] seq_pc(input logic [31:0] v);
    logic [32:0] sum;
    sum = {1'b0, v} + 33'd4;
    if (sum[32] || (sum[31:0] > PC_LIMIT)) return RESET_PC;
    return sum[31:0];
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      pc    <= RESET_PC;
      cnt   <= 16'd0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = cnt;
    SQUASH    = 1'b0;
    case (state)
      IDLE: state_nxt = LD_REQ ? LOAD : RUN;
      RUN, HOLD: begin
        if (LD_REQ) begin
          state_nxt = LOAD;
        end else if (BR_TAKEN) begin
          // Targets are word-aligned and never wrapped, even above the limit.
          pc_nxt    = {BR_TARGET[31:2], 2'b00};
          SQUASH    = 1'b1;
          state_nxt = RUN;
        end else if (STALL) begin
          cnt_nxt   = sat_inc(cnt);
          state_nxt = HOLD;
        end else begin
          pc_nxt    = seq_pc(pc);
          state_nxt = RUN;
        end
      end
      LOAD: begin
        if (LD_DONE) begin
          pc_nxt    = RESET_PC;
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign FETCH_ADR   = pc;
  assign FETCH_VALID = (state == RUN) || (state == HOLD);
  assign LD_GNT      = (state == LOAD);
  assign STALL_CNT   = cnt;

endmodule
